// File: rtl/regbank_sequencer.sv
// Instruction sequencer for a register bank and a multi-cycle ALU.
// Flow: IDLE -> DECODE -> EXECUTE -> WRITEBACK, with a NOP shortcut and an ALU timeout abort.
module regbank_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [15:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             alu_done,
    output logic [2:0]       alu_op,
    output logic             alu_start,
    output logic [2:0]       srcreg1_sel,
    output logic [2:0]       srcreg2_sel,
    output logic [2:0]       destreg_sel,
    output logic             wr_en,
    output logic             timeout_err,
    output logic [CNT_W-1:0] retired
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    state_t           r_state;
    logic [15:4]      r_instr;
    logic             r_ready;
    logic             r_alu_start;
    logic             r_wr_en;
    logic             r_timeout_err;
    logic [TW-1:0]    r_exec_cnt;
    logic [CNT_W-1:0] r_retired;
    logic             w_instr_unused;

    // Bits [3:0] carry no meaning for the sequencer.
    assign w_instr_unused = ^instr[3:0];

    // Sequencer state, captured instruction and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_instr       <= 12'd0;
            r_ready       <= 1'b1;
            r_alu_start   <= 1'b0;
            r_wr_en       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_exec_cnt    <= '0;
            r_retired     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (instr_valid && r_ready) begin
                        r_instr <= instr[15:4];
                        r_ready <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (r_instr[15:13] == OP_NOP) begin
                        r_retired <= r_retired + CNT_W'(1);
                        r_ready   <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_alu_start <= 1'b1;
                        r_exec_cnt  <= TW'(1);
                        r_state     <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    r_alu_start <= 1'b0;
                    // Done wins over timeout on the final permitted cycle.
                    if (alu_done) begin
                        r_wr_en    <= 1'b1;
                        r_exec_cnt <= '0;
                        r_state    <= S_WRITEBACK;
                    end else if (r_exec_cnt == TW'(TIMEOUT)) begin
                        r_timeout_err <= 1'b1;
                        r_exec_cnt    <= '0;
                        r_ready       <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_exec_cnt <= r_exec_cnt + TW'(1);
                    end
                end
                S_WRITEBACK: begin
                    r_wr_en   <= 1'b0;
                    r_retired <= r_retired + CNT_W'(1);
                    r_ready   <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_alu_start <= 1'b0;
                    r_wr_en     <= 1'b0;
                    r_exec_cnt  <= '0;
                    r_ready     <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign alu_op      = r_instr[15:13];
    assign destreg_sel = r_instr[12:10];
    assign srcreg1_sel = r_instr[9:7];
    assign srcreg2_sel = r_instr[6:4];
    assign alu_start   = r_alu_start;
    assign wr_en       = r_wr_en;
    assign timeout_err = r_timeout_err;
    assign retired     = r_retired;

endmodule

// File: tb/tb_regbank_sequencer.sv
// Directed self-checking bench for regbank_sequencer (retired counter narrowed to 4 bits to reach wrap quickly).
module tb_regbank_sequencer;

    localparam int CW = 4;

    logic          clk;
    logic          reset_n;
    logic [15:0]   instr;
    logic          instr_valid;
    logic          instr_ready;
    logic          alu_done;
    logic [2:0]    alu_op;
    logic          alu_start;
    logic [2:0]    srcreg1_sel;
    logic [2:0]    srcreg2_sel;
    logic [2:0]    destreg_sel;
    logic          wr_en;
    logic          timeout_err;
    logic [CW-1:0] retired;

    int errors = 0;
    int checks = 0;
    int n_wr = 0;
    int n_start = 0;

    regbank_sequencer #(.TIMEOUT(15), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_done(alu_done), .alu_op(alu_op),
        .alu_start(alu_start), .srcreg1_sel(srcreg1_sel), .srcreg2_sel(srcreg2_sel),
        .destreg_sel(destreg_sel), .wr_en(wr_en), .timeout_err(timeout_err),
        .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (wr_en === 1'b1) n_wr++;
        if (alu_start === 1'b1) n_start++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [15:0] ins);
        instr       = ins;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        int wr0;
        int st0;
        reset_n     = 1'b0;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        alu_done    = 1'b0;
        tick();
        tick();
        check("rst_ready",   32'(instr_ready), 32'd1);
        check("rst_start",   32'(alu_start),   32'd0);
        check("rst_wr",      32'(wr_en),       32'd0);
        check("rst_op",      32'(alu_op),      32'd0);
        check("rst_sels",    32'({srcreg1_sel, srcreg2_sel, destreg_sel}), 32'd0);
        check("rst_tmo",     32'(timeout_err), 32'd0);
        check("rst_retired", 32'(retired),     32'd0);
        reset_n = 1'b1;
        tick();

        // ADD 16'h2A50, done one cycle after the start pulse
        wr0 = n_wr;
        issue(16'h2A50);
        check("add_dec_ready", 32'(instr_ready), 32'd0);
        check("add_src1",      32'(srcreg1_sel), 32'd4);
        check("add_src2",      32'(srcreg2_sel), 32'd5);
        check("add_op",        32'(alu_op),      32'd1);
        check("add_dec_start", 32'(alu_start),   32'd0);
        tick();
        check("add_start",     32'(alu_start),   32'd1);
        check("add_ex1_wr",    32'(wr_en),       32'd0);
        tick();
        check("add_start_1cy", 32'(alu_start),   32'd0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("add_wr",        32'(wr_en),       32'd1);
        check("add_dest",      32'(destreg_sel), 32'd2);
        tick();
        check("add_wr_off",    32'(wr_en),       32'd0);
        check("add_retired",   32'(retired),     32'd1);
        check("add_ready",     32'(instr_ready), 32'd1);
        check("add_nwr",       32'(n_wr - wr0),  32'd1);

        // NOP: no start, no write, retired still counts
        wr0 = n_wr;
        st0 = n_start;
        issue(16'hE000);
        check("nop_dec_ready", 32'(instr_ready), 32'd0);
        tick();
        check("nop_ready",     32'(instr_ready), 32'd1);
        check("nop_retired",   32'(retired),     32'd2);
        check("nop_nstart",    32'(n_start - st0), 32'd0);
        check("nop_nwr",       32'(n_wr - wr0),  32'd0);

        // Done arrives on EXECUTE cycle 15: still a success
        wr0 = n_wr;
        issue(16'h3E50);
        tick();
        for (int i = 0; i < 14; i++) tick();
        check("c15_ready",     32'(instr_ready), 32'd0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("c15_wr",        32'(wr_en),       32'd1);
        check("c15_dest",      32'(destreg_sel), 32'd7);
        check("c15_tmo",       32'(timeout_err), 32'd0);
        tick();
        check("c15_retired",   32'(retired),     32'd3);
        check("c15_nwr",       32'(n_wr - wr0),  32'd1);

        // Done never comes: abort after 15 EXECUTE cycles
        wr0 = n_wr;
        issue(16'h4C90);
        tick();
        for (int i = 0; i < 14; i++) tick();
        check("tmo_c15_busy",  32'(instr_ready), 32'd0);
        check("tmo_c15_flag",  32'(timeout_err), 32'd0);
        tick();
        check("tmo_flag",      32'(timeout_err), 32'd1);
        check("tmo_ready",     32'(instr_ready), 32'd1);
        check("tmo_retired",   32'(retired),     32'd3);
        check("tmo_nwr",       32'(n_wr - wr0),  32'd0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("idle_done_nowr", 32'(wr_en),      32'd0);

        // Next instruction after a timeout, minimum latency, flag sticky
        issue(16'h2A50);
        tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("lat3_wr",       32'(wr_en),       32'd1);
        tick();
        check("lat3_retired",  32'(retired),     32'd4);
        check("tmo_sticky",    32'(timeout_err), 32'd1);

        // Reset during EXECUTE
        wr0 = n_wr;
        issue(16'h2A50);
        tick();
        check("rx_in_exec",    32'(alu_start),   32'd1);
        reset_n = 1'b0;
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        check("rx_ready",      32'(instr_ready), 32'd1);
        check("rx_start",      32'(alu_start),   32'd0);
        check("rx_wr",         32'(wr_en),       32'd0);
        check("rx_op",         32'(alu_op),      32'd0);
        check("rx_sels",       32'({srcreg1_sel, srcreg2_sel, destreg_sel}), 32'd0);
        check("rx_tmo",        32'(timeout_err), 32'd0);
        check("rx_retired",    32'(retired),     32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        check("rx_nwr",        32'(n_wr - wr0),  32'd0);

        // Retired wrap: 15 NOPs then one ADD
        for (int i = 0; i < 15; i++) begin
            issue(16'hE000);
            tick();
        end
        check("wrap_pre",      32'(retired),     32'd15);
        issue(16'h2A50);
        tick();
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        tick();
        check("wrap_zero",     32'(retired),     32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
